// File: rtl/instr_register_pkg.sv
// ---------------------------------------------------------------------------
// instr_register_pkg
// Shared types for the 32-entry instruction register and its read/write
// agents.
//   opcode_t      : 4-bit operation code. Encodings 8..15 are unused.
//   operand_t     : signed 32-bit operand.
//   instruction_t : packed {opc, op_a, op_b}, exactly as stored in the register.
//   result_t      : signed 64-bit execution result.
// ---------------------------------------------------------------------------
package instr_register_pkg;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef logic signed [31:0] operand_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    typedef logic signed [63:0] result_t;

endpackage

// File: rtl/instr_reader_exec_if.sv
// ---------------------------------------------------------------------------
// instr_reader_exec_if
// Bundles every non-clock/reset signal of instr_reader_exec.
//   start/start_ptr/count     : range request (driven by the controller)
//   busy/done                 : status back to the controller
//   read_pointer              : address to the instruction register
//   instruction_word          : combinational read data from the register
//   res_valid/res_ready       : result stream handshake
//   res_ptr/res_opcode/result/div_zero : result payload
// Modports:
//   slave  : the reader/executor itself
//   master : the environment around it (controller, register, sink)
// ---------------------------------------------------------------------------
interface instr_reader_exec_if #(
    parameter int ADDR_W = 5
);
    import instr_register_pkg::*;

    logic              start;
    logic [ADDR_W-1:0] start_ptr;
    logic [ADDR_W:0]   count;
    logic              busy;
    logic [ADDR_W-1:0] read_pointer;
    instruction_t      instruction_word;
    logic              res_valid;
    logic              res_ready;
    logic [ADDR_W-1:0] res_ptr;
    opcode_t           res_opcode;
    result_t           result;
    logic              div_zero;
    logic              done;

    modport slave (
        input  start, start_ptr, count, instruction_word, res_ready,
        output busy, read_pointer, res_valid, res_ptr, res_opcode,
               result, div_zero, done
    );

    modport master (
        output start, start_ptr, count, instruction_word, res_ready,
        input  busy, read_pointer, res_valid, res_ptr, res_opcode,
               result, div_zero, done
    );

endinterface

// File: rtl/instr_alu.sv
// ---------------------------------------------------------------------------
// instr_alu
// Purely combinational executor for one instruction.
//   i_opcode   : operation to perform
//   i_op_a     : signed 32-bit operand a
//   i_op_b     : signed 32-bit operand b
//   o_result   : signed 64-bit result (operands are sign-extended first)
//   o_div_zero : DIV or MOD attempted with op_b == 0 (result forced to 0)
// Unused opcode encodings yield 0 with o_div_zero low.
// ---------------------------------------------------------------------------
module instr_alu
    import instr_register_pkg::*;
(
    input  opcode_t  i_opcode,
    input  operand_t i_op_a,
    input  operand_t i_op_b,
    output result_t  o_result,
    output logic     o_div_zero
);

    // Working in 64 bits keeps ADD/SUB free of 32-bit overflow, gives MULT
    // its full product and makes -2^31 / -1 representable.
    result_t w_a;
    result_t w_b;

    assign w_a = result_t'(i_op_a);
    assign w_b = result_t'(i_op_b);

    always_comb begin
        // NOTE: defaults first so no path leaves an output unassigned, which would infer a latch.
        o_result   = '0;
        o_div_zero = 1'b0;
        case (i_opcode)
            ZERO:  o_result = '0;
            PASSA: o_result = w_a;
            PASSB: o_result = w_b;
            ADD:   o_result = w_a + w_b;
            SUB:   o_result = w_a - w_b;
            MULT:  o_result = w_a * w_b;
            // Signed / and % truncate toward zero, so the remainder follows
            // the dividend's sign.
            DIV: begin
                if (w_b == '0) o_div_zero = 1'b1;
                else           o_result   = w_a / w_b;
            end
            MOD: begin
                if (w_b == '0) o_div_zero = 1'b1;
                else           o_result   = w_a % w_b;
            end
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/instr_reader_exec.sv
// ---------------------------------------------------------------------------
// instr_reader_exec
// Walks a contiguous, wrapping range of instruction-register locations,
// executes each stored instruction and streams the results out.
//   clk   : sole clock, rising edge
//   reset : synchronous, active-high
//   bus   : instr_reader_exec_if.slave (request, register read port,
//           result stream, busy/done status)
// Per location: READ (address out, capture word) -> EXEC (compute, register)
// -> OUT (hold until res_ready). done pulses the cycle after the last
// handshake, or the cycle after a start with count == 0.
// ---------------------------------------------------------------------------
module instr_reader_exec
    import instr_register_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32      // must equal 2**ADDR_W
) (
    input  logic                clk,
    input  logic                reset,
    instr_reader_exec_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        OUT  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   ONE_CNT   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ONE_PTR   = ADDR_W'(1);

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_remaining;
    instruction_t      r_instr;
    result_t           r_result;
    logic [ADDR_W-1:0] r_res_ptr;
    opcode_t           r_res_opcode;
    logic              r_div_zero;
    logic              r_done;

    result_t           w_alu_result;
    logic              w_alu_div_zero;
    logic              w_handshake;
    logic              w_last;

    assign w_handshake = (r_state == OUT) && bus.res_ready;
    assign w_last      = (r_remaining == ONE_CNT);

    instr_alu u_alu (
        .i_opcode   (r_instr.opc),
        .i_op_a     (r_instr.op_a),
        .i_op_b     (r_instr.op_b),
        .o_result   (w_alu_result),
        .o_div_zero (w_alu_div_zero)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        w_next_state  = r_state;
        bus.busy      = (r_state != IDLE);
        bus.res_valid = (r_state == OUT);
        case (r_state)
            IDLE: if (bus.start && (bus.count != '0)) w_next_state = READ;
            READ: w_next_state = EXEC;
            EXEC: w_next_state = OUT;
            OUT:  if (w_handshake) w_next_state = w_last ? IDLE : READ;
            default: w_next_state = IDLE;
        endcase
    end

    // Counters, captured instruction and output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr        <= '0;
            r_remaining  <= '0;
            // NOTE: r_instr is reset along with the rest so EXEC can never compute from X after reset.
            r_instr      <= '0;
            r_result     <= '0;
            r_res_ptr    <= '0;
            r_res_opcode <= ZERO;
            r_div_zero   <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so every register samples pre-edge values regardless of statement order.
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.count == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_ptr       <= bus.start_ptr;
                            r_remaining <= (bus.count > DEPTH_CNT) ? DEPTH_CNT : bus.count;
                        end
                    end
                end
                READ: r_instr <= bus.instruction_word;
                EXEC: begin
                    r_result     <= w_alu_result;
                    r_div_zero   <= w_alu_div_zero;
                    r_res_opcode <= r_instr.opc;
                    r_res_ptr    <= r_ptr;
                end
                OUT: begin
                    if (bus.res_ready) begin
                        r_remaining <= r_remaining - ONE_CNT;
                        // The pointer only moves when another READ follows,
                        // so read_pointer changes solely on entry to READ.
                        // The natural ADDR_W-bit wrap gives 31 -> 0.
                        if (w_last) r_done <= 1'b1;
                        else        r_ptr  <= r_ptr + ONE_PTR;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.read_pointer = r_ptr;
    assign bus.res_ptr      = r_res_ptr;
    assign bus.res_opcode   = r_res_opcode;
    assign bus.result       = r_result;
    assign bus.div_zero     = r_div_zero;
    assign bus.done         = r_done;

endmodule

// File: doc/instr_reader_exec.md
# instr_reader_exec

Read-side consumer for the 32-entry instruction register. On a start pulse it walks a contiguous, wrapping range of register locations, reads each stored instruction through the register's read port, and executes the opcode on the operands. Each result is presented on a valid/ready output stream, and a done pulse marks the end of the range. It sits opposite the write-side loader, on the same register's `read_pointer` / `instruction_word` port.

## Interface
Parameters:
- `ADDR_W`, 5: register address width.
- `DEPTH`, 32: number of register locations; must equal 2**ADDR_W.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `start_ptr`  in  ADDR_W  first location to read.
- `count`  in  ADDR_W+1  number of locations to read; values above DEPTH are clamped to DEPTH.
- `busy`  out  1  high in every state except IDLE.
- `read_pointer`  out  ADDR_W  address driven to the instruction register.
- `instruction_word`  in  instruction_t  combinational read data: `{opc, op_a, op_b}`.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  downstream accepts the result.
- `res_ptr`  out  ADDR_W  location the result came from.
- `res_opcode`  out  opcode_t  executed opcode.
- `result`  out  result_t  signed 64-bit result.
- `div_zero`  out  1  qualified by `res_valid`; DIV or MOD with op_b == 0.
- `done`  out  1  one-cycle pulse when the range completes.

## Operation
- **FSM states:** IDLE, READ, EXEC, OUT.
- **IDLE:**
  - `start` with count ≠ 0: latch ptr = start_ptr and remaining = min(count, DEPTH), then go to READ.
  - `start` with count == 0: pulse `done` on the next cycle and stay in IDLE.
  - `start` in any other state is ignored.
- **READ:**
  - `read_pointer` = ptr.
  - Capture `instruction_word` into the internal instruction register at the end of the cycle.
  - Go to EXEC.
- **EXEC:**
  - Compute the result from the captured word and register it.
  - Set `res_ptr` = ptr.
  - Go to OUT.
- **OUT:**
  - `res_valid` = 1.
  - `result`, `res_ptr`, `res_opcode` and `div_zero` stay stable until the handshake.
  - On `res_valid && res_ready`:
    - ptr = (ptr + 1) mod DEPTH, wrapping 31→0.
    - remaining decrements.
    - If remaining was 1: pulse `done` and go to IDLE. Otherwise go to READ.
- **Arithmetic:** op_a and op_b are signed 32-bit; all results are sign-extended to 64 bits.
  - ZERO = 0.
  - PASSA = a.
  - PASSB = b.
  - ADD = a + b.
  - SUB = a − b.
  - MULT = full 64-bit product.
  - DIV truncates toward zero.
  - MOD takes the sign of the dividend.
  - DIV or MOD with b == 0: result = 0 and `div_zero` = 1.
  - An opcode encoding outside the enum gives result = 0 and `div_zero` = 0.

## Timing
- **Reset values:** `busy`, `res_valid`, `done`, `div_zero` = 0; `read_pointer`, `res_ptr`, `result` = 0; `res_opcode` = ZERO.
- **Latency:** `start` sampled at edge N → READ in cycle N+1 → `res_valid` high in cycle N+3.
- **Throughput:** at most one result per 3 cycles with `res_ready` tied high.
- **Done:** `done` is asserted in the cycle after the final handshake, together with `busy` = 0.
- **Backpressure:** with `res_ready` low, OUT holds indefinitely and `read_pointer` holds its value.
- **Reset mid-operation:** the next edge returns the block to IDLE with all outputs at their reset values. No `done` is issued. The in-flight result is dropped.
- **Read source:** `read_pointer` changes only on entry to READ; the read is combinational within that cycle.

## Structure
- **Shared package `instr_register_pkg`:**
  - Existing types: `opcode_t`, `operand_t`, `instruction_t`.
  - Add `result_t` (logic signed [63:0]).
- **Sub-module `instr_alu`:** combinational; inputs are opcode, op_a and op_b; outputs are result and `div_zero`. It is instantiated once in EXEC's datapath.
- **Top:** FSM, pointer/remaining counters, and the output register.

## Test plan
- **Basic range:** preload loc0 = {ADD, 5, 3}, loc1 = {SUB, −4, 6}, loc2 = {MULT, −7, 9}; start_ptr = 0, count = 3, `res_ready` = 1 → results 8, −10, −63 at cycles N+3, N+6, N+9; `done` at N+10.
- **Wrap:** start_ptr = 30, count = 4 → `res_ptr` sequence 30, 31, 0, 1.
- **Divide rules:** loc5 = {DIV, −7, 2} → −3; loc6 = {MOD, −7, 2} → −1; loc7 = {DIV, 9, 0} → 0 with `div_zero` = 1.
- **Backpressure:** hold `res_ready` = 0 for 5 cycles in OUT → outputs stable and `read_pointer` unchanged; the handshake then advances to the next location.
- **Edge counts:**
  - count = 0 → `done` only, no `res_valid`.
  - count = 40 → exactly 32 results.
  - `start` while busy → ignored.
- **Reset mid-run:** assert `reset` while in OUT of result 2 of 4 → outputs at reset values on the next edge, no `done`; a following start runs normally.
